// File: rtl/scan_seq_ctrl_pkg.sv
// Shared scan-chain defaults and FSM state encodings for the scan sequencer and its integration.
package scan_seq_ctrl_pkg;

    localparam int unsigned SI_LEN_DEF = 188;
    localparam int unsigned SO_LEN_DEF = 50;
    localparam int unsigned PH_CYC_DEF = 1;

    localparam int unsigned ST_W = 4;
    localparam int unsigned PH_W = 8;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 4'd0,
        S_SETUP  = 4'd1,
        S_PHI    = 4'd2,
        S_GAP1   = 4'd3,
        S_PHIB   = 4'd4,
        S_GAP2   = 4'd5,
        S_LOAD   = 4'd6,
        S_LGAP   = 4'd7,
        S_SEL    = 4'd8,
        S_CPHI   = 4'd9,
        S_CGAP1  = 4'd10,
        S_CPHIB  = 4'd11,
        S_CGAP2  = 4'd12,
        S_DESEL  = 4'd13,
        S_SAMPLE = 4'd14,
        S_RSP    = 4'd15
    } scan_state_e;

    // States that are not paced by the phase step timer.
    function automatic logic is_untimed(input scan_state_e s);
        return (s == S_IDLE) || (s == S_RSP);
    endfunction

endpackage

// File: rtl/scan_step_timer.sv
// Phase step timer: down-counts PH_CYC cycles per FSM step and flags the last cycle.
module scan_step_timer
    import scan_seq_ctrl_pkg::*;
#(
    parameter int unsigned PH_CYC = PH_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    output logic o_step_done_c
);

    localparam logic [PH_W-1:0] RELOAD = PH_W'(PH_CYC - 1);

    logic [PH_W-1:0] r_cnt;

    assign o_step_done_c = (r_cnt == '0);

    // Reload at each step boundary or while the FSM sits in an untimed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_hold || o_step_done_c) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - PH_W'(1);
        end
    end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan chain sequencer: shift-in/load and capture/shift-out with two-phase non-overlapping clocks.
module scan_seq_ctrl
    import scan_seq_ctrl_pkg::*;
#(
    parameter int unsigned SI_LEN = SI_LEN_DEF,
    parameter int unsigned SO_LEN = SO_LEN_DEF,
    parameter int unsigned PH_CYC = PH_CYC_DEF
) (
    input  logic              clk_signal_ext,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [SI_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [SO_LEN-1:0] rsp_data,
    output logic              phi,
    output logic              phib,
    output logic              load,
    output logic              scan_i0o1,
    output logic              scan_in,
    input  logic              scan_out,
    output logic              busy
);

    localparam int unsigned MAX_LEN = (SI_LEN > SO_LEN) ? SI_LEN : SO_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

    scan_state_e       r_state;
    scan_state_e       w_state_nxt;
    logic              r_op;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [SI_LEN-1:0] r_si_word;
    logic [SO_LEN-1:0] r_cap;
    logic [SO_LEN-1:0] r_rsp_data;
    logic              r_phi;
    logic              r_phib;
    logic              r_load;
    logic              r_scan_i0o1;
    logic              r_scan_in;
    logic              r_rsp_valid;
    logic              r_cmd_ready;
    logic              r_busy;

    logic              w_step_done;
    logic              w_hold;
    logic              w_accept;
    logic              w_last_bit;
    logic              w_phi_nxt;
    logic              w_phib_nxt;
    logic              w_load_nxt;
    logic              w_i0o1_nxt;
    logic              w_rsp_nxt;
    logic              w_idle_nxt;

    assign w_hold     = is_untimed(r_state);
    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_last_bit = (r_bit_cnt == CNT_W'(1));

    scan_step_timer #(
        .PH_CYC (PH_CYC)
    ) u_step_timer (
        .clk           (clk_signal_ext),
        .rst_n         (rst_n),
        .i_hold        (w_hold),
        .o_step_done_c (w_step_done)
    );

    // Next-state sequencing plus decode of the chain controls for the upcoming state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid)   w_state_nxt = cmd_op ? S_SEL : S_SETUP;
            S_SETUP:  if (w_step_done) w_state_nxt = S_PHI;
            S_SAMPLE: if (w_step_done) w_state_nxt = S_PHI;
            S_PHI:    if (w_step_done) w_state_nxt = S_GAP1;
            S_GAP1:   if (w_step_done) w_state_nxt = S_PHIB;
            S_PHIB:   if (w_step_done) w_state_nxt = S_GAP2;
            S_GAP2: begin
                if (w_step_done) begin
                    if (w_last_bit) w_state_nxt = r_op ? S_RSP : S_LOAD;
                    else            w_state_nxt = r_op ? S_SAMPLE : S_SETUP;
                end
            end
            S_LOAD:   if (w_step_done) w_state_nxt = S_LGAP;
            S_LGAP:   if (w_step_done) w_state_nxt = S_IDLE;
            S_SEL:    if (w_step_done) w_state_nxt = S_CPHI;
            S_CPHI:   if (w_step_done) w_state_nxt = S_CGAP1;
            S_CGAP1:  if (w_step_done) w_state_nxt = S_CPHIB;
            S_CPHIB:  if (w_step_done) w_state_nxt = S_CGAP2;
            S_CGAP2:  if (w_step_done) w_state_nxt = S_DESEL;
            S_DESEL:  if (w_step_done) w_state_nxt = S_SAMPLE;
            S_RSP:                     w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase

        w_phi_nxt  = (w_state_nxt == S_PHI)  || (w_state_nxt == S_CPHI);
        w_phib_nxt = (w_state_nxt == S_PHIB) || (w_state_nxt == S_CPHIB);
        w_load_nxt = (w_state_nxt == S_LOAD);
        w_i0o1_nxt = (w_state_nxt == S_SEL)   || (w_state_nxt == S_CPHI)  ||
                     (w_state_nxt == S_CGAP1) || (w_state_nxt == S_CPHIB) ||
                     (w_state_nxt == S_CGAP2);
        w_rsp_nxt  = (w_state_nxt == S_RSP);
        w_idle_nxt = (w_state_nxt == S_IDLE);
    end

    // State, registered chain controls and datapath; reset abandons any command in flight.
    always_ff @(posedge clk_signal_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_bit_cnt   <= '0;
            r_si_word   <= '0;
            r_cap       <= '0;
            r_rsp_data  <= '0;
            r_phi       <= 1'b0;
            r_phib      <= 1'b0;
            r_load      <= 1'b0;
            r_scan_i0o1 <= 1'b0;
            r_scan_in   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phi       <= w_phi_nxt;
            r_phib      <= w_phib_nxt;
            r_load      <= w_load_nxt;
            r_scan_i0o1 <= w_i0o1_nxt;
            r_rsp_valid <= w_rsp_nxt;
            r_cmd_ready <= w_idle_nxt;
            r_busy      <= !w_idle_nxt;

            if (w_accept) begin
                r_op      <= cmd_op;
                r_bit_cnt <= cmd_op ? CNT_W'(SO_LEN) : CNT_W'(SI_LEN);
                r_si_word <= cmd_data << 1;
                r_cap     <= '0;
                r_scan_in <= !cmd_op && cmd_data[SI_LEN-1];
            end else if ((r_state == S_GAP2) && w_step_done) begin
                r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                if (!r_op && !w_last_bit) begin
                    r_scan_in <= r_si_word[SI_LEN-1];
                    r_si_word <= r_si_word << 1;
                end else begin
                    r_scan_in <= 1'b0;
                end
            end

            if ((r_state == S_SAMPLE) && w_step_done) begin
                r_cap <= {r_cap[SO_LEN-2:0], scan_out};
            end

            if (w_rsp_nxt) begin
                r_rsp_data <= r_cap;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign phi       = r_phi;
    assign phib      = r_phib;
    assign load      = r_load;
    assign scan_i0o1 = r_scan_i0o1;
    assign scan_in   = r_scan_in;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Scoreboard bench for scan_seq_ctrl: default-size instance (PH_CYC=1) and a small PH_CYC=3 instance.
module tb_scan_seq_ctrl;

    localparam int unsigned A_SI = 188;
    localparam int unsigned A_SO = 50;
    localparam int unsigned B_SI = 12;
    localparam int unsigned B_SO = 10;
    localparam int unsigned B_PH = 3;

    typedef struct {
        bit           is_rsp;
        logic [187:0] word;
        logic [49:0]  rsp;
        int           acc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic            a_rst_n, a_valid, a_ready, a_op, a_rsp_valid, a_busy;
    logic [A_SI-1:0] a_data;
    logic [A_SO-1:0] a_rsp_data;
    logic            a_phi, a_phib, a_load, a_i0o1, a_scan_in, a_scan_out;
    // Instance B signals
    logic            b_rst_n, b_valid, b_ready, b_op, b_rsp_valid, b_busy;
    logic [B_SI-1:0] b_data;
    logic [B_SO-1:0] b_rsp_data;
    logic            b_phi, b_phib, b_load, b_i0o1, b_scan_in, b_scan_out;

    scan_seq_ctrl #(.SI_LEN(A_SI), .SO_LEN(A_SO), .PH_CYC(1)) dut_a (
        .clk_signal_ext (clk),        .rst_n     (a_rst_n),
        .cmd_valid      (a_valid),    .cmd_ready (a_ready),
        .cmd_op         (a_op),       .cmd_data  (a_data),
        .rsp_valid      (a_rsp_valid),.rsp_data  (a_rsp_data),
        .phi            (a_phi),      .phib      (a_phib),
        .load           (a_load),     .scan_i0o1 (a_i0o1),
        .scan_in        (a_scan_in),  .scan_out  (a_scan_out),
        .busy           (a_busy)
    );

    scan_seq_ctrl #(.SI_LEN(B_SI), .SO_LEN(B_SO), .PH_CYC(B_PH)) dut_b (
        .clk_signal_ext (clk),        .rst_n     (b_rst_n),
        .cmd_valid      (b_valid),    .cmd_ready (b_ready),
        .cmd_op         (b_op),       .cmd_data  (b_data),
        .rsp_valid      (b_rsp_valid),.rsp_data  (b_rsp_data),
        .phi            (b_phi),      .phib      (b_phib),
        .load           (b_load),     .scan_i0o1 (b_i0o1),
        .scan_in        (b_scan_in),  .scan_out  (b_scan_out),
        .busy           (b_busy)
    );

    exp_t            qa[$];
    exp_t            qb[$];
    logic [A_SO-1:0] cwq_a[$];
    logic [B_SO-1:0] cwq_b[$];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Chain models: capture on phib during select, shift on phib otherwise; scan_out is the chain MSB.
    logic [A_SO-1:0] a_chain = '0;
    logic [B_SO-1:0] b_chain = '0;
    logic            ca_pphib = 1'b0;
    logic            cb_pphib = 1'b0;
    assign a_scan_out = a_chain[A_SO-1];
    assign b_scan_out = b_chain[B_SO-1];

    always @(negedge clk) begin
        if (a_phib && !ca_pphib) begin
            if (a_i0o1) begin
                if (cwq_a.size() > 0) a_chain = cwq_a.pop_front();
            end else begin
                a_chain = {a_chain[A_SO-2:0], a_scan_in};
            end
        end
        ca_pphib = a_phib;
        if (b_phib && !cb_pphib) begin
            if (b_i0o1) begin
                if (cwq_b.size() > 0) b_chain = cwq_b.pop_front();
            end else begin
                b_chain = {b_chain[B_SO-2:0], b_scan_in};
            end
        end
        cb_pphib = b_phib;
    end

    // Monitor A: rebuild shifted word, protocol checks, pop scoreboard on load / rsp_valid.
    logic [A_SI-1:0] a_rebuilt = '0;
    logic            pa_phi = 0, pa_phib = 0, pa_load = 0, pa_rsp = 0, pa_i0o1 = 0;
    int              a_phi_run = 0, a_phib_run = 0, a_load_run = 0;
    int              a_load_cnt = 0, a_rsp_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!a_rst_n) begin
            pa_phi = 0; pa_phib = 0; pa_load = 0; pa_rsp = 0; pa_i0o1 = 0;
            a_phi_run = 0; a_phib_run = 0; a_load_run = 0;
        end else begin
            chk("a_overlap", {a_phi & a_phib, a_load & (a_phi | a_phib)}, 0);
            if (a_i0o1 != pa_i0o1) chk("a_i0o1_under_phase", a_phi | a_phib | pa_phi | pa_phib, 0);
            if (a_phi && !pa_phi && !a_i0o1) a_rebuilt = {a_rebuilt[A_SI-2:0], a_scan_in};
            if (a_phi) a_phi_run++;
            else if (pa_phi) begin chk("a_phi_width", a_phi_run, 1); a_phi_run = 0; end
            if (a_phib) a_phib_run++;
            else if (pa_phib) begin chk("a_phib_width", a_phib_run, 1); a_phib_run = 0; end
            if (a_load) begin
                a_load_run++;
                if (!pa_load) begin
                    a_load_cnt++;
                    if (qa.size() == 0) chk("a_unexpected_load", 1, 0);
                    else begin
                        e = qa.pop_front();
                        chk("a_load_for_op0", e.is_rsp, 0);
                        chk("a_word", a_rebuilt, e.word);
                        chk("a_load_lat", cyc - e.acc, e.lat);
                    end
                end
            end else if (pa_load) begin
                chk("a_load_width", a_load_run, 1); a_load_run = 0;
            end
            if (a_rsp_valid) begin
                chk("a_rsp_pulse", pa_rsp, 0);
                a_rsp_cnt++;
                if (qa.size() == 0) chk("a_unexpected_rsp", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_rsp_for_op1", e.is_rsp, 1);
                    chk("a_rsp_data", a_rsp_data, e.rsp);
                    chk("a_rsp_lat", cyc - e.acc, e.lat);
                end
            end
            pa_phi = a_phi; pa_phib = a_phib; pa_load = a_load; pa_rsp = a_rsp_valid; pa_i0o1 = a_i0o1;
        end
    end

    // Monitor B: same checks with PH_CYC=3 step widths.
    logic [B_SI-1:0] b_rebuilt = '0;
    logic            pb_phi = 0, pb_phib = 0, pb_load = 0, pb_rsp = 0, pb_i0o1 = 0;
    int              b_phi_run = 0, b_phib_run = 0, b_load_run = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!b_rst_n) begin
            pb_phi = 0; pb_phib = 0; pb_load = 0; pb_rsp = 0; pb_i0o1 = 0;
            b_phi_run = 0; b_phib_run = 0; b_load_run = 0;
        end else begin
            chk("b_overlap", {b_phi & b_phib, b_load & (b_phi | b_phib)}, 0);
            if (b_i0o1 != pb_i0o1) chk("b_i0o1_under_phase", b_phi | b_phib | pb_phi | pb_phib, 0);
            if (b_phi && !pb_phi && !b_i0o1) b_rebuilt = {b_rebuilt[B_SI-2:0], b_scan_in};
            if (b_phi) b_phi_run++;
            else if (pb_phi) begin chk("b_phi_width", b_phi_run, B_PH); b_phi_run = 0; end
            if (b_phib) b_phib_run++;
            else if (pb_phib) begin chk("b_phib_width", b_phib_run, B_PH); b_phib_run = 0; end
            if (b_load) begin
                b_load_run++;
                if (!pb_load) begin
                    if (qb.size() == 0) chk("b_unexpected_load", 1, 0);
                    else begin
                        e = qb.pop_front();
                        chk("b_load_for_op0", e.is_rsp, 0);
                        chk("b_word", b_rebuilt, e.word);
                        chk("b_load_lat", cyc - e.acc, e.lat);
                    end
                end
            end else if (pb_load) begin
                chk("b_load_width", b_load_run, B_PH); b_load_run = 0;
            end
            if (b_rsp_valid) begin
                chk("b_rsp_pulse", pb_rsp, 0);
                if (qb.size() == 0) chk("b_unexpected_rsp", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_rsp_for_op1", e.is_rsp, 1);
                    chk("b_rsp_data", b_rsp_data, e.rsp);
                    chk("b_rsp_lat", cyc - e.acc, e.lat);
                end
            end
            pb_phi = b_phi; pb_phib = b_phib; pb_load = b_load; pb_rsp = b_rsp_valid; pb_i0o1 = b_i0o1;
        end
    end

    task automatic wait_a_ready(input string nm);
        int t = 0;
        while (!a_ready && t < 5000) begin @(negedge clk); t++; end
        if (!a_ready) chk(nm, 0, 1);
    endtask

    // Issue one command on A, push its expected response, and check accept-to-IDLE latency.
    task automatic send_a(input bit op, input logic [A_SI-1:0] data, input logic [A_SO-1:0] cw);
        exp_t e;
        @(negedge clk);
        wait_a_ready("a_ready_timeout_pre");
        e.is_rsp = op; e.word = 188'(data); e.rsp = cw; e.acc = cyc + 1;
        e.lat = op ? 256 : 940;
        if (op) cwq_a.push_back(cw);
        qa.push_back(e);
        a_valid = 1'b1; a_op = op; a_data = data;
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_busy_after_accept", {a_busy, a_ready}, 2'b10);
        wait_a_ready("a_ready_timeout_post");
        if (op) chk("a_op1_idle_lat", cyc - e.acc, 257);
        else    chk("a_op0_idle_lat", cyc - e.acc, 942);
    endtask

    task automatic send_b(input bit op, input logic [B_SI-1:0] data, input logic [B_SO-1:0] cw);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!b_ready && t < 2000) begin @(negedge clk); t++; end
        if (!b_ready) begin chk("b_ready_timeout", 0, 1); return; end
        e.is_rsp = op; e.word = 188'(data); e.rsp = 50'(cw); e.acc = cyc + 1;
        e.lat = op ? int'((6 + 5 * B_SO) * B_PH) : int'(5 * B_SI * B_PH);
        if (op) cwq_b.push_back(cw);
        qb.push_back(e);
        b_valid = 1'b1; b_op = op; b_data = data;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [A_SI-1:0] d;
        logic [A_SO-1:0] w;
        exp_t            e;
        int              l0, r0, cnt, t;
        logic            pphi;

        a_rst_n = 0; b_rst_n = 0;
        a_valid = 0; a_op = 0; a_data = '0;
        b_valid = 0; b_op = 0; b_data = '0;
        repeat (3) @(negedge clk);
        chk("a_reset_ctrls", {a_phi, a_phib, a_load, a_i0o1, a_scan_in, a_rsp_valid, a_busy}, 0);
        chk("a_reset_rsp_data", a_rsp_data, 0);
        chk("b_reset_ctrls", {b_phi, b_phib, b_load, b_i0o1, b_scan_in, b_rsp_valid, b_busy}, 0);
        a_rst_n = 1; b_rst_n = 1;
        @(negedge clk);
        chk("a_ready_after_reset", {a_ready, a_busy}, 2'b10);
        chk("b_ready_after_reset", {b_ready, b_busy}, 2'b10);

        // Shift-in of MSB-and-A5 pattern, then capture/shift-out of a known chain word.
        d = (188'h1 << 187) | 188'hA5;
        send_a(1'b0, d, '0);
        chk("a_single_load", a_load_cnt, 1);
        w = 50'h2_AAAA_5555_1234;
        send_a(1'b1, '0, w);
        chk("a_single_rsp", a_rsp_cnt, 1);
        repeat (5) @(negedge clk);
        chk("a_rsp_data_hold", a_rsp_data, w);
        d = {47{4'h5}};
        send_a(1'b0, d, '0);
        chk("a_rsp_data_hold_op0", a_rsp_data, w);

        // cmd_valid held high across two commands: second accepted on the IDLE-entry cycle.
        l0 = a_load_cnt; r0 = a_rsp_cnt;
        @(negedge clk);
        wait_a_ready("a_ready_timeout_q");
        d = {94{2'b10}};
        w = 50'h3_0F0F_00FF_C3A5;
        e.is_rsp = 0; e.word = d; e.rsp = '0; e.acc = cyc + 1; e.lat = 940;
        qa.push_back(e);
        a_valid = 1'b1; a_op = 1'b0; a_data = d;
        @(negedge clk);
        a_op = 1'b1; a_data = '1;
        e.is_rsp = 1; e.word = '0; e.rsp = w; e.acc = e.acc + 943; e.lat = 256;
        qa.push_back(e);
        cwq_a.push_back(w);
        wait_a_ready("a_ready_timeout_q1");
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_queued_second_accepted", a_busy, 1);
        wait_a_ready("a_ready_timeout_q2");
        chk("a_queued_loads", a_load_cnt - l0, 1);
        chk("a_queued_rsps", a_rsp_cnt - r0, 1);

        // Reset while shifting bit 50 of an all-ones word.
        l0 = a_load_cnt; r0 = a_rsp_cnt;
        @(negedge clk);
        a_valid = 1'b1; a_op = 1'b0; a_data = '1;
        @(negedge clk);
        a_valid = 1'b0;
        cnt = 0; t = 0; pphi = 1'b0;
        do begin
            if (a_phi && !pphi) cnt++;
            pphi = a_phi;
            if (cnt < 50) begin @(negedge clk); t++; end
        end while (cnt < 50 && t < 2000);
        chk("a_reached_bit50", {cnt, a_phi, a_scan_in}, {50, 1'b1, 1'b1});
        #2 a_rst_n = 1'b0;
        #1;
        chk("a_rst_chain_outputs", {a_phi, a_phib, a_load, a_i0o1, a_scan_in, a_rsp_valid}, 0);
        chk("a_rst_rsp_data", a_rsp_data, 0);
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk);
        chk("a_ready_after_mid_reset", {a_ready, a_busy}, 2'b10);
        repeat (1000) @(negedge clk);
        chk("a_no_load_after_reset", a_load_cnt, l0);
        chk("a_no_rsp_after_reset", a_rsp_cnt, r0);

        // PH_CYC=3: twenty back-to-back ops with random data and chain words.
        for (int k = 0; k < 20; k++) begin
            send_b(1'($urandom_range(0, 1)), B_SI'($urandom), B_SO'($urandom));
        end
        t = 0;
        while (!(b_ready && qb.size() == 0) && t < 2000) begin @(negedge clk); t++; end
        chk("b_drain", {b_ready, 32'(qb.size())}, {1'b1, 32'd0});
        chk("a_queue_empty", qa.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
